mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single RAM port (mem_size/addr/data_i/data_o) between the CPU instruction-fetch port (IF) and load/store port (LS). Each requester uses a req/ack handshake. The arbiter grants one requester, holds the RAM access for a fixed latency, then returns read data with a one-cycle ack. It sits between the CPU and RAM in the top-level and testbench.

Parameters:
MEM_LATENCY, 2, cycles the RAM request is held before data_o is sampled (min 1)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  IF request; held until if_ack
if_addr  input  ADDR_W  IF address (always word read)
if_ack  output  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  output  32  fetched word
ls_req  input  1  LS request; held until ls_ack
ls_we  input  1  1 = store, 0 = load
ls_size  input  2  00 byte, 01 half, 10 word (11 is illegal)
ls_addr  input  ADDR_W  LS address
ls_wdata  input  32  store data
ls_ack  output  1  one-cycle pulse completing LS access
ls_err  output  1  valid with ls_ack; misaligned or illegal size
ls_rdata  output  32  load data, valid with ls_ack
mem_size  output  2  to RAM
addr  output  ADDR_W  to RAM
data_i  output  32  write data to RAM
mem_we  output  1  RAM write enable
data_o  input  32  read data from RAM

Behaviour:
- Reset values: state IDLE; if_ack=0, ls_ack=0, ls_err=0, if_rdata=0, ls_rdata=0, mem_we=0, mem_size=2'b10, addr=0, data_i=0; last-grant = IF.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - No request: stay.
  - LS wins and access is misaligned (word with addr[1:0]!=0, half with addr[0]!=0, or size 11): go to ACK with ls_err=1. No RAM access; mem_we stays 0.
  - Otherwise: latch winner, addr, size, we and wdata into RAM outputs. Load counter with MEM_LATENCY-1. Go to BUSY.
- BUSY: outputs held stable. mem_we=1 only for an LS store. Counter decrements. At 0, capture data_o into the winner's rdata register, deassert mem_we, go to ACK.
- ACK: the winner's ack=1 for exactly one cycle. Update last-grant. Return to IDLE.
- Latency: request seen in IDLE at cycle N gives ack at cycle N+MEM_LATENCY+1. Error ack comes at N+1.
- Requester must drop req in the cycle after ack. A req still high in IDLE is a new request.
- Requester inputs are sampled only in IDLE; changes during BUSY are ignored.
- Stores: ls_rdata is undefined (holds its previous value); ls_err=0.
- Simultaneous if_req and ls_req in IDLE: arbitration policy (see Optional Feature) decides. The loser waits; it is never dropped.
- rdata registers hold their value until the next ack for that port.
- Reset asserted mid-access: immediate return to reset values. The in-flight access is abandoned and no ack is issued.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: on a tie, the port not granted last wins; last-grant updates in ACK.
- Undefined: fixed priority, LS always beats IF; the last-grant register is not synthesised.

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - state encodings ST_IDLE, ST_BUSY, ST_ACK;
  - port IDs PORT_IF, PORT_LS.
- One sub-module, mem_arb_align_chk: combinational misalignment/illegal-size check from size and addr[1:0].

Test Plan:
- IF only, if_addr=0x100, RAM word 0x00000013, MEM_LATENCY=2 -> if_ack at request cycle+3, if_rdata=0x00000013, mem_we never 1.
- LS word store, addr=0x200, wdata=0xDEADBEEF -> mem_we=1 for exactly 2 cycles with addr=0x200, mem_size=10; ls_ack with ls_err=0. A following IF read of 0x200 returns 0xDEADBEEF.
- LS half load at addr=0x203 -> ls_ack next cycle with ls_err=1, mem_we=0, no addr change. Size 11 at 0x200 -> same error response.
- if_req and ls_req high together, held for 4 accesses:
  - without the macro -> every grant goes to LS until ls_req drops;
  - with the macro -> grants alternate LS, IF, LS, IF.
- Reset pulsed during BUSY of an LS store -> mem_we=0 and all acks 0 immediately. After release, a fresh IF request completes normally.
- MEM_LATENCY=1 -> ack at request cycle+2; back-to-back IF requests give one ack every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/LS memory arbiter: access sizes, FSM states, port IDs.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    // True when an access of this size cannot be issued from this byte offset,
    // or when the size code itself is not a legal one.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_align_chk.sv
// Flags misaligned LS accesses (half on odd byte, word off 4-byte boundary) and size 2'b11.
// Latency: purely combinational.
// Backpressure: none; result is consumed only while the arbiter is idle.
module mem_arb_align_chk
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       err_o
);

    // Decode the size/offset pair into a single error flag.
    always_comb begin
        err_o = access_bad(size_i, addr_lo_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch (IF) and load/store (LS) with req/ack handshakes.
// Latency: request seen idle at cycle N acks at N+MEM_LATENCY+1; a rejected LS access acks at N+1.
// Backpressure: requester holds req until its one-cycle ack; the loser of a tie waits in place.
// Build option MEM_ARB_ROUND_ROBIN_EN: ties alternate between ports; otherwise LS always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ack,
    output logic              ls_err,
    output logic [31:0]       ls_rdata,

    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_i,
    output logic              mem_we,
    input  logic [31:0]       data_o
);

    // Counter only needs to reach MEM_LATENCY-1; keep at least one bit.
    localparam int             CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    port_t             grant_q,    grant_d;
    logic              err_q,      err_d;
    logic              we_q,       we_d;
    logic [1:0]        size_q,     size_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_t             last_q,     last_d;
`endif

    port_t win;
    logic  ls_misalign;

    mem_arb_align_chk u_align_chk (
        .size_i    (ls_size),
        .addr_lo_i (ls_addr[1:0]),
        .err_o     (ls_misalign)
    );

    // Pick the requester that would be granted if the arbiter were idle this cycle.
    always_comb begin
        win = PORT_IF;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = (last_q == PORT_LS) ? PORT_IF : PORT_LS;
`else
            win = PORT_LS;
`endif
        end else if (ls_req) begin
            win = PORT_LS;
        end
    end

    // Next-state and datapath updates for the IDLE/BUSY/ACK access sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        err_d      = err_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    grant_d = win;
                    if ((win == PORT_LS) && ls_misalign) begin
                        // Rejected access never touches the RAM outputs.
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_BUSY;
                        if (win == PORT_LS) begin
                            addr_d  = ls_addr;
                            size_d  = ls_size;
                            we_d    = ls_we;
                            wdata_d = ls_wdata;
                        end else begin
                            addr_d  = if_addr;
                            size_d  = SIZE_WORD;
                            we_d    = 1'b0;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    we_d    = 1'b0;
                    state_d = ST_ACK;
                    if (grant_q == PORT_IF) begin
                        if_rdata_d = data_o;
                    end else if (!we_q) begin
                        // Stores leave the load-data register untouched.
                        ls_rdata_d = data_o;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_d  = grant_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_q    <= PORT_IF;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SIZE_WORD;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember which port completed last so the next tie goes the other way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign if_ack   = (state_q == ST_ACK) && (grant_q == PORT_IF);
    assign ls_ack   = (state_q == ST_ACK) && (grant_q == PORT_LS);
    assign ls_err   = ls_ack && err_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_size = size_q;
    assign addr     = addr_q;
    assign data_i   = wdata_q;
    assign mem_we   = we_q;

endmodule
